fetch_stage: RTL

Instruction-fetch stage of the amber pipeline, directly upstream of decode. Keeps the fetch address, issues word fetches over a req/ack instruction-memory port, and drives the IF/ID pipeline register. It takes the hazard unit's stall to freeze IF/ID, parking at most one in-flight response in a one-entry buffer. It takes execute-stage redirects to squash and re-steer fetch.

---
 rtl/fetch_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch, req/ack imem port, IF/ID register.
// One-entry skid buffer absorbs a response that lands during a stall.
module fetch_stage #(
  parameter int ADDR_W = 24,
  parameter int INSTR_W = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               iw_clk,
  input  logic               iw_rst_n,
  input  logic               iw_stall,
  input  logic               iw_redirect,
  input  logic [ADDR_W-1:0]  iw_redirect_pc,
  output logic               ow_imem_req,
  output logic [ADDR_W-1:0]  ow_imem_addr,
  input  logic               iw_imem_ack,
  input  logic [INSTR_W-1:0] iw_imem_data,
  output logic               ow_ifid_valid,
  output logic [ADDR_W-1:0]  ow_ifid_pc,
  output logic [INSTR_W-1:0] ow_ifid_instr
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_tgt;
  logic [ADDR_W-1:0]  r_buf_pc;
  logic [INSTR_W-1:0] r_buf_instr;

  assign ow_imem_req  = (state == S_REQ) || (state == S_DROP);
  assign ow_imem_addr = r_addr;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state         <= S_BOOT;
      r_addr        <= RESET_PC;
      r_tgt         <= '0;
      r_buf_pc      <= '0;
      r_buf_instr   <= '0;
      ow_ifid_valid <= 1'b0;
      ow_ifid_pc    <= '0;
      ow_ifid_instr <= '0;
    end else begin
      unique case (state)
        S_BOOT: state <= S_REQ;
        S_REQ: begin
          if (iw_redirect) begin
            ow_ifid_valid <= 1'b0;
            if (iw_imem_ack) begin
              r_addr <= iw_redirect_pc;
            end else begin
              // outstanding request keeps its address; park target
              r_tgt <= iw_redirect_pc;
              state <= S_DROP;
            end
          end else if (iw_imem_ack) begin
            r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            if (iw_stall) begin
              r_buf_pc    <= r_addr;
              r_buf_instr <= iw_imem_data;
              state       <= S_FULL;
            end else begin
              ow_ifid_valid <= 1'b1;
              ow_ifid_pc    <= r_addr;
              ow_ifid_instr <= iw_imem_data;
            end
          end else if (!iw_stall) begin
            ow_ifid_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (iw_redirect) begin
            ow_ifid_valid <= 1'b0;
            r_addr        <= iw_redirect_pc;
            state         <= S_REQ;
          end else if (!iw_stall) begin
            ow_ifid_valid <= 1'b1;
            ow_ifid_pc    <= r_buf_pc;
            ow_ifid_instr <= r_buf_instr;
            state         <= S_REQ;
          end
        end
        S_DROP: begin
          ow_ifid_valid <= 1'b0;
          if (iw_redirect) begin
            r_tgt <= iw_redirect_pc;
          end else if (iw_imem_ack) begin
            r_addr <= r_tgt;
            state  <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule
